// File: rtl/leds_pkg.sv
// Shared types and constants for the LED bank driver.
package leds_pkg;

    localparam int LED_MODE_W  = 2;
    // Widest PWM resolution a channel configuration can carry.
    localparam int LED_LEVEL_W = 16;

    typedef enum logic [LED_MODE_W-1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_t;

    // Levels are stored zero-extended to LED_LEVEL_W bits.
    typedef struct packed {
        led_mode_t                mode;
        logic [LED_LEVEL_W-1:0]   level;
    } led_cfg_t;

    typedef enum logic [1:0] {
        PEND_EMPTY = 2'd0,
        PEND_FULL  = 2'd1,
        PEND_DRAIN = 2'd2
    } pend_state_t;

    // Counter width for a modulo-count counter, never narrower than one bit.
    function automatic int width_of(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/leds_channel.sv
// One LED channel: configuration register, optional breathe ramp and the
// registered PWM output bit.
// Optional feature macro: LEDS_BREATHE_EN (without it, BREATHE renders as ON).
module led_channel
    import leds_pkg::*;
#(
    parameter int leds_pwm_bits = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  led_cfg_t                 load_cfg,
`ifdef LEDS_BREATHE_EN
    input  logic                     frame_wrap,
`endif
    input  logic [leds_pwm_bits-1:0] pwm_cnt,
    input  logic                     blink_phase,
    output logic                     led
);

    localparam logic [LED_LEVEL_W-1:0] LEVEL_FULL = LED_LEVEL_W'((2 ** leds_pwm_bits) - 1);

    led_cfg_t                 cfg;
    logic [LED_LEVEL_W-1:0]   pwm_ext;
    logic                     on_rule;
    logic                     led_next;

    // Configuration register, loaded on the edge that starts a new frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            cfg <= '{mode: LED_OFF, level: '0};
        end else if (load) begin
            cfg <= load_cfg;
        end
    end

    assign pwm_ext = LED_LEVEL_W'(pwm_cnt);
    // Full-scale level is solid on rather than lit for all but one tick.
    assign on_rule = (cfg.level == LEVEL_FULL) || (pwm_ext < cfg.level);

`ifdef LEDS_BREATHE_EN
    logic [leds_pwm_bits-1:0] ramp;
    logic                     ramp_up;
    logic [LED_LEVEL_W-1:0]   ramp_ext;

    assign ramp_ext = LED_LEVEL_W'(ramp);

    // Triangle ramp 0..level..0, one step per frame; any write restarts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            ramp    <= '0;
            ramp_up <= 1'b1;
        end else if (load) begin
            ramp    <= '0;
            ramp_up <= 1'b1;
        end else if (frame_wrap) begin
            if (ramp_up) begin
                if (ramp_ext < cfg.level) begin
                    ramp <= ramp + 1'b1;
                end else begin
                    ramp_up <= 1'b0;
                    if (ramp != '0) begin
                        ramp <= ramp - 1'b1;
                    end
                end
            end else begin
                if (ramp != '0) begin
                    ramp <= ramp - 1'b1;
                end else begin
                    ramp_up <= 1'b1;
                    if (cfg.level != '0) begin
                        ramp <= ramp + 1'b1;
                    end
                end
            end
        end
    end
`endif

    // Next output bit from the current mode and PWM position.
    always_comb begin
        led_next = 1'b0;
        case (cfg.mode)
            LED_OFF:     led_next = 1'b0;
            LED_ON:      led_next = on_rule;
            LED_BLINK:   led_next = on_rule & blink_phase;
`ifdef LEDS_BREATHE_EN
            LED_BREATHE: led_next = (pwm_ext < ramp_ext);
`else
            LED_BREATHE: led_next = on_rule;
`endif
            default:     led_next = 1'b0;
        endcase
    end

    // Registered LED drive, one clock behind pwm_cnt.
    always_ff @(posedge clock) begin
        if (reset) begin
            led <= 1'b0;
        end else begin
            led <= led_next;
        end
    end

endmodule

// File: rtl/leds.sv
// LED bank driver: shared PWM timebase, blink phase, single-slot command
// buffer and one led_channel per output.
// Optional feature macro: LEDS_BREATHE_EN (per-channel breathe ramps).
//
// Pending-slot FSM
//   state      | meaning
//   PEND_EMPTY | slot free, cmd_ready high
//   PEND_FULL  | command held, waiting for the next frame boundary
//   PEND_DRAIN | command applied this boundary, slot frees after frame_start
module leds
    import leds_pkg::*;
#(
    parameter int leds_frequency = 100000000,
    parameter int leds_number    = 16,
    parameter int leds_pwm_bits  = 8,
    parameter int leds_tick_div  = 390,
    parameter int leds_blink_ms  = 250
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [$clog2(leds_number)-1:0] cmd_index,
    input  logic [LED_MODE_W-1:0]          cmd_mode,
    input  logic [leds_pwm_bits-1:0]       cmd_level,
    output logic                           frame_start,
    output logic [leds_number-1:0]         led
);

    localparam int IDX_W      = $clog2(leds_number);
    localparam int PRESC_W    = width_of(leds_tick_div);
    localparam int BLINK_CLKS = leds_frequency / 1000 * leds_blink_ms;
    localparam int BLINK_W    = width_of(BLINK_CLKS);

    logic [PRESC_W-1:0]       presc;
    logic                     tick;
    logic [leds_pwm_bits-1:0] pwm_cnt;
    logic                     frame_wrap;
    logic [BLINK_W-1:0]       blink_cnt;
    logic                     blink_last;
    logic                     blink_phase;

    pend_state_t              pend_state;
    pend_state_t              pend_next;
    logic [IDX_W-1:0]         pend_index;
    led_cfg_t                 pend_cfg;
    logic                     accept;
    logic                     apply;

    assign tick       = (presc == PRESC_W'(leds_tick_div - 1));
    // Edge on which pwm_cnt returns to 0; frame_start follows it by one clock.
    assign frame_wrap = tick && (pwm_cnt == '1);
    assign blink_last = (blink_cnt == BLINK_W'(BLINK_CLKS - 1));
    assign accept     = cmd_valid && cmd_ready;

    // PWM tick prescaler.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // PWM position counter and the frame_start pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // Free-running blink phase shared by all channels.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_last) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Pending-slot state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_state <= PEND_EMPTY;
        end else begin
            pend_state <= pend_next;
        end
    end

    // Pending-slot next state, ready and apply strobe.
    always_comb begin
        pend_next = pend_state;
        cmd_ready = 1'b0;
        apply     = 1'b0;
        case (pend_state)
            PEND_EMPTY: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    pend_next = PEND_FULL;
                end
            end
            PEND_FULL: begin
                if (frame_wrap) begin
                    apply     = 1'b1;
                    pend_next = PEND_DRAIN;
                end
            end
            PEND_DRAIN: begin
                if (frame_start) begin
                    pend_next = PEND_EMPTY;
                end
            end
            default: pend_next = PEND_EMPTY;
        endcase
    end

    // Capture the accepted command into the pending slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_index <= '0;
            pend_cfg   <= '{mode: LED_OFF, level: '0};
        end else if (accept) begin
            pend_index     <= cmd_index;
            pend_cfg.mode  <= led_mode_t'(cmd_mode);
            pend_cfg.level <= LED_LEVEL_W'(cmd_level);
        end
    end

    // An index with no matching channel is simply dropped at the boundary.
    for (genvar i = 0; i < leds_number; i++) begin : g_chan
        led_channel #(
            .leds_pwm_bits (leds_pwm_bits)
        ) u_channel (
            .clock       (clock),
            .reset       (reset),
            .load        (apply && (pend_index == IDX_W'(i))),
            .load_cfg    (pend_cfg),
`ifdef LEDS_BREATHE_EN
            .frame_wrap  (frame_wrap),
`endif
            .pwm_cnt     (pwm_cnt),
            .blink_phase (blink_phase),
            .led         (led[i])
        );
    end

endmodule
